fpga_config_sequencer: RTL and testbench

- Wishbone-slave controller that sequences loading of the FPGA fabric's configuration shift chain and then commits the loaded bits.
- Sits between the Caravel Wishbone port and the fabric's config tiles.
- Accepts 32-bit bitstream words, serialises them LSB-first onto the chain and pulses the latch-set line.
- Releases fabric enable only after a complete, committed load.

---
 rtl/fpga_config_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_fpga_config_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_config_sequencer.sv
// rtl/fpga_config_sequencer.sv - Wishbone-fed loader for the fabric config shift chain.
// Define FPGA_CONFIG_READBACK_EN to add the cfg_tail input and the READBACK capture register.
module fpga_config_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          CHAIN_BITS = 1024,
  parameter int          SET_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_data_i,
  input  logic [31:0] wbs_addr_i,
`ifdef FPGA_CONFIG_READBACK_EN
  input  logic        cfg_tail,
`endif
  output logic        wbs_ack_o,
  output logic [31:0] wbs_data_o,
  output logic        cfg_data,
  output logic        cfg_shift_en,
  output logic        cfg_set,
  output logic        fpga_en
);

  localparam logic [15:0] CHAIN_END = 16'(CHAIN_BITS);
  localparam int          SET_W     = $clog2(SET_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SET_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SET,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [31:0]      shifter_q, shifter_d;
  logic [4:0]       word_cnt_q, word_cnt_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic             overflow_q, overflow_d;
  logic             early_q, early_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             cfg_data_q, cfg_data_d;
  logic             cfg_shift_en_q, cfg_shift_en_d;
  logic             cfg_set_q, cfg_set_d;
  logic             fpga_en_q, fpga_en_d;
`ifdef FPGA_CONFIG_READBACK_EN
  logic [31:0]      rb_q, rb_d;
`endif

  logic        req;
  logic [1:0]  word_off;
  logic        last_bit;
  logic        busy;
  logic [31:0] status_word;
  logic [31:0] readback_word;
  logic        unused_inputs;

  // The request mask on ack_q keeps a held strobe from being taken twice.
  assign req      = wbs_cyc_i & wbs_stb_i & (wbs_addr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
  assign word_off = wbs_addr_i[3:2];
  assign last_bit = (bit_cnt_q + 16'd1) == CHAIN_END;
  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_SET);
  assign status_word = {bit_cnt_q, 11'd0, early_q, overflow_q, state_q == ST_DONE, hold_full_q, busy};
  assign unused_inputs = ^{wbs_sel_i, wbs_addr_i[1:0]};

`ifdef FPGA_CONFIG_READBACK_EN
  assign readback_word = rb_q;
`else
  assign readback_word = 32'd0;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shifter_d   = shifter_q;
    word_cnt_d  = word_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    set_cnt_d   = set_cnt_q;
    overflow_d  = overflow_q;
    early_d     = early_q;
    ack_d       = 1'b0;
    rdata_d     = 32'd0;
`ifdef FPGA_CONFIG_READBACK_EN
    rb_d = cfg_shift_en_q ? {cfg_tail, rb_q[31:1]} : rb_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (hold_full_q) begin
          hold_full_d = 1'b0;
          if (bit_cnt_q == CHAIN_END) begin
            overflow_d = 1'b1;
          end else begin
            shifter_d  = hold_q;
            word_cnt_d = 5'd0;
            state_d    = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        bit_cnt_d  = bit_cnt_q + 16'd1;
        word_cnt_d = word_cnt_q + 5'd1;
        shifter_d  = {1'b0, shifter_q[31:1]};
        if (word_cnt_q == 5'd31 || last_bit) begin
          if (hold_full_q && !last_bit) begin
            shifter_d   = hold_q;
            hold_full_d = 1'b0;
            word_cnt_d  = 5'd0;
          end else begin
            // A word still queued when the chain fills has nowhere to go.
            if (hold_full_q) begin
              hold_full_d = 1'b0;
              overflow_d  = 1'b1;
            end
            state_d = ST_LOAD;
          end
        end
      end
      ST_SET: begin
        set_cnt_d = set_cnt_q + SET_W'(1);
        if (set_cnt_q == SET_LAST) state_d = ST_DONE;
      end
      default: ;
    endcase

    if (req) begin
      if (!wbs_we_i) begin
        ack_d = 1'b1;
        case (word_off)
          2'd1:    rdata_d = status_word;
          2'd3:    rdata_d = readback_word;
          default: rdata_d = 32'd0;
        endcase
      end else if (word_off == 2'd2) begin
        if (state_q == ST_IDLE) begin
          ack_d = 1'b1;
        end else if (bit_cnt_d == CHAIN_END) begin
          ack_d      = 1'b1;
          overflow_d = 1'b1;
        end else if (!hold_full_q) begin
          ack_d       = 1'b1;
          hold_d      = wbs_data_i;
          hold_full_d = 1'b1;
        end
      end else begin
        ack_d = 1'b1;
        if (word_off == 2'd0) begin
          if (wbs_data_i[2]) begin
            state_d     = ST_IDLE;
            hold_full_d = 1'b0;
          end else if (wbs_data_i[0]) begin
            if (state_q == ST_IDLE || state_q == ST_DONE) begin
              state_d     = ST_LOAD;
              bit_cnt_d   = 16'd0;
              hold_full_d = 1'b0;
              overflow_d  = 1'b0;
              early_d     = 1'b0;
            end
          end else if (wbs_data_i[1] && state_q == ST_LOAD) begin
            if (bit_cnt_q == CHAIN_END) begin
              state_d   = ST_SET;
              set_cnt_d = '0;
            end else begin
              early_d = 1'b1;
            end
          end
        end
      end
    end

    cfg_shift_en_d = (state_d == ST_SHIFT);
    cfg_data_d     = (state_d == ST_SHIFT) & shifter_d[0];
    cfg_set_d      = (state_d == ST_SET);
    fpga_en_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q        <= ST_IDLE;
      hold_q         <= 32'd0;
      hold_full_q    <= 1'b0;
      shifter_q      <= 32'd0;
      word_cnt_q     <= 5'd0;
      bit_cnt_q      <= 16'd0;
      set_cnt_q      <= '0;
      overflow_q     <= 1'b0;
      early_q        <= 1'b0;
      ack_q          <= 1'b0;
      rdata_q        <= 32'd0;
      cfg_data_q     <= 1'b0;
      cfg_shift_en_q <= 1'b0;
      cfg_set_q      <= 1'b0;
      fpga_en_q      <= 1'b0;
`ifdef FPGA_CONFIG_READBACK_EN
      rb_q           <= 32'd0;
`endif
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      shifter_q      <= shifter_d;
      word_cnt_q     <= word_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      set_cnt_q      <= set_cnt_d;
      overflow_q     <= overflow_d;
      early_q        <= early_d;
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
      cfg_data_q     <= cfg_data_d;
      cfg_shift_en_q <= cfg_shift_en_d;
      cfg_set_q      <= cfg_set_d;
      fpga_en_q      <= fpga_en_d;
`ifdef FPGA_CONFIG_READBACK_EN
      rb_q           <= rb_d;
`endif
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_data_o   = rdata_q;
  assign cfg_data     = cfg_data_q;
  assign cfg_shift_en = cfg_shift_en_q;
  assign cfg_set      = cfg_set_q;
  assign fpga_en      = fpga_en_q;

endmodule

// File: tb/tb_fpga_config_sequencer.sv
// tb/tb_fpga_config_sequencer.sv - directed bench for fpga_config_sequencer (CHAIN_BITS=40, SET_CYCLES=4).
module tb_fpga_config_sequencer;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [3:0]  A_CTRL   = 4'h0;
  localparam logic [3:0]  A_STATUS = 4'h4;
  localparam logic [3:0]  A_DATA   = 4'h8;
  localparam logic [3:0]  A_RB     = 4'hC;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_addr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_data_o;
  logic        cfg_data;
  logic        cfg_shift_en;
  logic        cfg_set;
  logic        fpga_en;

  int n_checks = 0;
  int n_fail   = 0;

  fpga_config_sequencer #(
    .BASE_ADDR (BASE),
    .CHAIN_BITS(40),
    .SET_CYCLES(4)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_data_i  (wbs_data_i),
    .wbs_addr_i  (wbs_addr_i),
`ifdef FPGA_CONFIG_READBACK_EN
    .cfg_tail    (cfg_tail),
`endif
    .wbs_ack_o   (wbs_ack_o),
    .wbs_data_o  (wbs_data_o),
    .cfg_data    (cfg_data),
    .cfg_shift_en(cfg_shift_en),
    .cfg_set     (cfg_set),
    .fpga_en     (fpga_en)
  );

`ifdef FPGA_CONFIG_READBACK_EN
  logic [39:0] chain = 40'd0;
  logic        cfg_tail;
  assign cfg_tail = chain[39];
  always @(posedge wb_clk_i) if (cfg_shift_en) chain <= {chain[38:0], cfg_data};
`endif

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int   sh_cnt  = 0;
  int   set_cnt = 0;
  int   rises   = 0;
  logic prev_en = 1'b0;
  logic bits_log [0:1023];

  always @(negedge wb_clk_i) begin
    if (cfg_shift_en) begin
      if (sh_cnt < 1024) bits_log[sh_cnt] = cfg_data;
      sh_cnt++;
      if (!prev_en) rises++;
    end
    if (cfg_set) set_cnt++;
    prev_en = cfg_shift_en;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] load_bits(input int base, input int n);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v[i] = bits_log[base + i];
    return v;
  endfunction

  task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int ncyc);
    @(negedge wb_clk_i);
    wbs_cyc_i  = 1'b1;
    wbs_stb_i  = 1'b1;
    wbs_we_i   = we;
    wbs_addr_i = BASE + 32'(off);
    wbs_data_i = wdata;
    ncyc = 0;
    do begin
      @(posedge wb_clk_i);
      #1;
      ncyc++;
    end while (!wbs_ack_o && ncyc < 100);
    rdata = wbs_data_o;
    if (!wbs_ack_o) check_eq("wb_ack_timeout", 64'd0, 64'd1);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [3:0] off, input logic [31:0] wdata);
    logic [31:0] rd;
    int n;
    wb_xfer(1'b1, off, wdata, rd, n);
  endtask

  task automatic wb_rd(input logic [3:0] off, output logic [31:0] rdata);
    int n;
    wb_xfer(1'b0, off, 32'd0, rdata, n);
  endtask

  task automatic wait_shifts(input int target);
    int t;
    t = 0;
    while (sh_cnt < target && t < 300) begin
      @(posedge wb_clk_i);
      t++;
    end
    repeat (4) @(posedge wb_clk_i);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!fpga_en && t < 100) begin
      @(posedge wb_clk_i);
      #1;
      t++;
    end
  endtask

  logic [31:0] rd;
  int base, r0, s0, n1, n2, n3;

  initial begin
    wb_rst_ni  = 1'b0;
    wbs_cyc_i  = 1'b0;
    wbs_stb_i  = 1'b0;
    wbs_we_i   = 1'b0;
    wbs_sel_i  = 4'hF;
    wbs_addr_i = 32'd0;
    wbs_data_i = 32'd0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check_eq("rst_ack", 64'(wbs_ack_o), 64'd0);
    check_eq("rst_shift_en", 64'(cfg_shift_en), 64'd0);
    check_eq("rst_cfg_set", 64'(cfg_set), 64'd0);
    check_eq("rst_fpga_en", 64'(fpga_en), 64'd0);
    check_eq("rst_cfg_data", 64'(cfg_data), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    wb_rd(A_STATUS, rd);
    check_eq("rst_status", 64'(rd), 64'd0);
    wb_rd(A_CTRL, rd);
    check_eq("ctrl_reads_zero", 64'(rd), 64'd0);
`ifndef FPGA_CONFIG_READBACK_EN
    wb_rd(A_RB, rd);
    check_eq("readback_zero", 64'(rd), 64'd0);
`endif

    // Basic load: two words, commit, latch pulse, enable.
    wb_wr(A_CTRL, 32'h1);
    base = sh_cnt; r0 = rises; s0 = set_cnt;
    wb_wr(A_DATA, 32'hA5A5_A5A5);
    wb_wr(A_DATA, 32'h0000_00FF);
    wait_shifts(base + 40);
    check_eq("a_shift_count", 64'(sh_cnt - base), 64'd40);
    check_eq("a_bits", load_bits(base, 40), 64'h00_FF_A5A5_A5A5);
    check_eq("a_no_bubble", 64'(rises - r0), 64'd1);
    wb_wr(A_CTRL, 32'h2);
    wait_done();
    check_eq("a_set_cycles", 64'(set_cnt - s0), 64'd4);
    check_eq("a_fpga_en", 64'(fpga_en), 64'd1);
    wb_rd(A_STATUS, rd);
    check_eq("a_status", 64'(rd), 64'h0028_0004);

    // Back-to-back writes: immediate second ack, third stalls until word one drains.
    wb_wr(A_CTRL, 32'h1);
    check_eq("b_fpga_en_drop", 64'(fpga_en), 64'd0);
    base = sh_cnt; r0 = rises; s0 = set_cnt;
    wb_xfer(1'b1, A_DATA, 32'hDEAD_BEEF, rd, n1);
    wb_xfer(1'b1, A_DATA, 32'h0000_0055, rd, n2);
    wb_xfer(1'b1, A_DATA, 32'h1234_5678, rd, n3);
    check_eq("b_ack2_latency", 64'(n2), 64'd2);
    check_eq("b_ack3_stall", 64'(n3), 64'd32);
    wait_shifts(base + 40);
    check_eq("b_shift_count", 64'(sh_cnt - base), 64'd40);
    check_eq("b_bits", load_bits(base, 40), 64'h00_55_DEAD_BEEF);
    check_eq("b_no_bubble", 64'(rises - r0), 64'd1);
    wb_rd(A_STATUS, rd);
    check_eq("b_status_load", 64'(rd), 64'h0028_0008);
    wb_wr(A_CTRL, 32'h2);
    wait_done();
    wb_rd(A_STATUS, rd);
    check_eq("b_status_done", 64'(rd), 64'h0028_000C);

    // Early commit, then overflow once the chain is full.
    wb_wr(A_CTRL, 32'h1);
    base = sh_cnt; s0 = set_cnt;
    wb_wr(A_DATA, 32'h1234_5678);
    wait_shifts(base + 32);
    check_eq("c_shift32", 64'(sh_cnt - base), 64'd32);
    wb_wr(A_CTRL, 32'h2);
    repeat (6) @(posedge wb_clk_i);
    #1;
    check_eq("c_no_set", 64'(set_cnt - s0), 64'd0);
    check_eq("c_no_en", 64'(fpga_en), 64'd0);
    wb_rd(A_STATUS, rd);
    check_eq("c_status_early", 64'(rd), 64'h0020_0010);
    wb_wr(A_DATA, 32'h0000_0003);
    wait_shifts(base + 40);
    wb_wr(A_DATA, 32'hFFFF_FFFF);
    repeat (5) @(posedge wb_clk_i);
    check_eq("c_shift_count", 64'(sh_cnt - base), 64'd40);
    check_eq("c_bits", load_bits(base, 40), 64'h00_03_1234_5678);
    wb_rd(A_STATUS, rd);
    check_eq("c_status_ovf", 64'(rd), 64'h0028_0018);

    // Abort at bit 10.
    wb_wr(A_CTRL, 32'h4);
    wb_wr(A_CTRL, 32'h1);
    base = sh_cnt;
    wb_wr(A_DATA, 32'h0000_02D5);
    repeat (10) @(posedge wb_clk_i);
    wb_wr(A_CTRL, 32'h4);
    check_eq("d_shift_en_low", 64'(cfg_shift_en), 64'd0);
    check_eq("d_fpga_en", 64'(fpga_en), 64'd0);
    repeat (3) @(posedge wb_clk_i);
    check_eq("d_shift_count", 64'(sh_cnt - base), 64'd10);
    check_eq("d_bits", load_bits(base, 10), 64'h2D5);
    wb_rd(A_STATUS, rd);
    check_eq("d_status", 64'(rd), 64'h000A_0000);

    // Async reset while the latch pulse and the COMMIT ack are both high.
    wb_wr(A_CTRL, 32'h1);
    base = sh_cnt;
    wb_wr(A_DATA, 32'h0F0F_0F0F);
    wb_wr(A_DATA, 32'h0000_0081);
    wait_shifts(base + 40);
    @(negedge wb_clk_i);
    wbs_cyc_i  = 1'b1;
    wbs_stb_i  = 1'b1;
    wbs_we_i   = 1'b1;
    wbs_addr_i = BASE + 32'(A_CTRL);
    wbs_data_i = 32'h2;
    @(posedge wb_clk_i);
    #2;
    check_eq("e_ack_pre_rst", 64'(wbs_ack_o), 64'd1);
    check_eq("e_set_pre_rst", 64'(cfg_set), 64'd1);
    wb_rst_ni = 1'b0;
    #1;
    check_eq("e_ack_rst", 64'(wbs_ack_o), 64'd0);
    check_eq("e_set_rst", 64'(cfg_set), 64'd0);
    check_eq("e_en_rst", 64'(fpga_en), 64'd0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    wb_rd(A_STATUS, rd);
    check_eq("e_status_after_rst", 64'(rd), 64'd0);
    wb_wr(A_CTRL, 32'h1);
    base = sh_cnt; s0 = set_cnt;
    wb_wr(A_DATA, 32'hCAFE_F00D);
    wb_wr(A_DATA, 32'h0000_003C);
    wait_shifts(base + 40);
    check_eq("e_bits", load_bits(base, 40), 64'h00_3C_CAFE_F00D);
    wb_wr(A_CTRL, 32'h2);
    wait_done();
    check_eq("e_set_cycles", 64'(set_cnt - s0), 64'd4);
    check_eq("e_fpga_en", 64'(fpga_en), 64'd1);
    wb_rd(A_STATUS, rd);
    check_eq("e_status", 64'(rd), 64'h0028_0004);
`ifdef FPGA_CONFIG_READBACK_EN
    wb_rd(A_RB, rd);
    check_eq("readback_prev_load", 64'(rd), 64'h810F_0F0F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
